// File: rtl/input_load_sequencer_pkg.sv
// Shared types and constants for the SNN input loader: FSM state encoding,
// default frame size and byte width.
package snn_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_BYTE, SHIFT, START, RUN} seq_state_t;
    localparam int DEFAULT_NUM_PIXELS = 784;
    localparam int BYTE_BITS = 8;
endpackage

// File: rtl/input_load_sequencer_if.sv
// Control/data bundle between the load sequencer and its byte serializer.
interface input_load_sequencer_if;
    import snn_pkg::*;
    logic                 load;
    logic                 shift_en;
    logic [BYTE_BITS-1:0] din;
    logic                 msb;
    logic                 last_bit;

    modport master (output load, shift_en, din, input msb, last_bit);
    modport slave  (input load, shift_en, din, output msb, last_bit);
endinterface

// File: rtl/input_load_sequencer_byte_serializer.sv
// Parallel-load, MSB-first shift register with a bit counter that flags the
// last bit of the byte.
module byte_serializer
    import snn_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input_load_sequencer_if.slave ser
);
    logic [BYTE_BITS-1:0] shift_q;
    logic [2:0]           cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (ser.load) begin
            shift_q <= ser.din;
            cnt_q   <= '0;
        end else if (ser.shift_en) begin
            shift_q <= {shift_q[BYTE_BITS-2:0], 1'b0};
            cnt_q   <= cnt_q + 3'd1;
        end
    end

    assign ser.msb      = shift_q[BYTE_BITS-1];
    assign ser.last_bit = (cnt_q == 3'(BYTE_BITS-1));
endmodule

// File: rtl/input_load_sequencer.sv
// Streams UART bytes MSB-first into the 1-bit input RAM, then launches snn_core.
// Optional inter-byte timeout abort: define LOAD_TIMEOUT_EN.
module input_load_sequencer
    import snn_pkg::*;
#(
    parameter int NUM_PIXELS     = DEFAULT_NUM_PIXELS,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_rdy,
    input  logic [BYTE_BITS-1:0]  rx_data,
    output logic                  clr_rx_rdy,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic                  core_done,
    output logic                  start,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wdata,
    output logic                  busy,
    output logic                  load_err
);
    seq_state_t            state_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  rx_accept;
    logic                  last_pix;

    input_load_sequencer_if ser_bus ();
    byte_serializer u_ser (.clk(clk), .rst(rst), .ser(ser_bus.slave));

    // A pending byte is only taken while waiting for data; elsewhere it stays pending.
    assign rx_accept        = rx_rdy && (state_q == IDLE || state_q == WAIT_BYTE);
    assign last_pix         = (wr_addr_q == ADDR_WIDTH'(NUM_PIXELS - 1));
    assign ser_bus.load     = rx_accept;
    assign ser_bus.shift_en = (state_q == SHIFT);
    assign ser_bus.din      = rx_data;

`ifdef LOAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            load_err_q;
    assign load_err = load_err_q;
`else
    assign load_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
`ifdef LOAD_TIMEOUT_EN
            to_cnt_q   <= '0;
            load_err_q <= 1'b0;
`endif
        end else begin
`ifdef LOAD_TIMEOUT_EN
            load_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: if (rx_rdy) state_q <= SHIFT;
                WAIT_BYTE: begin
                    if (rx_rdy) state_q <= SHIFT;
`ifdef LOAD_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q    <= IDLE;
                        wr_addr_q  <= '0;
                        load_err_q <= 1'b1;
                    end else to_cnt_q <= to_cnt_q + TO_W'(1);
`endif
                end
                SHIFT: begin
                    wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
                    // Frame end wins over byte end: leftover bits of the last byte are dropped.
                    if (last_pix) state_q <= START;
                    else if (ser_bus.last_bit) begin
                        state_q <= WAIT_BYTE;
`ifdef LOAD_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                    end
                end
                START: state_q <= RUN;
                RUN: if (core_done) begin
                    state_q   <= IDLE;
                    wr_addr_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are gated by rst so a level on rx_rdy/core_addr cannot leak during reset.
    assign clr_rx_rdy = rx_accept && !rst;
    assign start      = (state_q == START);
    assign ram_we     = (state_q == SHIFT);
    assign ram_wdata  = (state_q == SHIFT) && ser_bus.msb;
    assign ram_addr   = rst ? '0 : ((state_q == SHIFT) ? wr_addr_q : core_addr);
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_input_load_sequencer.sv
// Scoreboard bench: expected RAM writes queued as bytes are sent, popped on ram_we.
module tb_input_load_sequencer;
    localparam int NP = 784, AW = 10, NP1 = 20;

    logic clk = 1'b0, rst;
    always #10 clk = ~clk;

    logic          rx_rdy, clr_rx_rdy, core_done, start, ram_we, ram_wdata, busy, load_err;
    logic [7:0]    rx_data;
    logic [AW-1:0] core_addr, ram_addr;
    logic          rx_rdy1, clr1, core_done1, start1, ram_we1, ram_wdata1, busy1, load_err1;
    logic [7:0]    rx_data1;
    logic [AW-1:0] core_addr1, ram_addr1;

    input_load_sequencer #(.NUM_PIXELS(NP), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
        .core_addr(core_addr), .core_done(core_done), .start(start), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .busy(busy), .load_err(load_err));

    input_load_sequencer #(.NUM_PIXELS(NP1), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(100)) dut1 (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy1), .rx_data(rx_data1), .clr_rx_rdy(clr1),
        .core_addr(core_addr1), .core_done(core_done1), .start(start1), .ram_we(ram_we1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .busy(busy1), .load_err(load_err1));

    typedef struct { int addr; bit d; } wr_t;
    wr_t exp_q[$];
    int  vec = 0, err = 0, cyc = 0, exp_addr = 0;
    int  start_cnt = 0, start_cyc = 0, le_cnt = 0, le_cyc = 0, cap_cyc = 0;
    int  w1_cnt = 0, w1_last = -1, start1_cnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon0
        wr_t e;
        if (!rst) begin
            if (ram_we) begin
                vec++;
                if (exp_q.size() == 0) begin
                    err++;
                    $display("FAIL wr_unexpected: got addr=%0d d=%0b, required no write", ram_addr, ram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (ram_addr !== AW'(e.addr) || ram_wdata !== e.d) begin
                        err++;
                        $display("FAIL wr_data: got addr=%0d d=%0b, required addr=%0d d=%0b",
                                 ram_addr, ram_wdata, e.addr, e.d);
                    end
                end
            end
            if (start) begin start_cnt++; start_cyc = cyc; end
            if (load_err) begin le_cnt++; le_cyc = cyc; end
        end
    end

    always @(negedge clk) begin : mon1
        if (!rst) begin
            if (ram_we1) begin
                vec++;
                if (ram_addr1 !== AW'(w1_cnt) || ram_wdata1 !== 1'b1) begin
                    err++;
                    $display("FAIL small_wr: got addr=%0d d=%0b, required addr=%0d d=1", ram_addr1, ram_wdata1, w1_cnt);
                end
                w1_last = int'(ram_addr1);
                w1_cnt++;
            end
            if (start1) start1_cnt++;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back('{exp_addr, b[i]});
            exp_addr++;
            if (exp_addr == NP) begin exp_addr = 0; break; end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        @(posedge clk); #1;
        rx_data = b; rx_rdy = 1'b1;
        push_byte(b);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (clr_rx_rdy === 1'b1) begin got = 1; break; end
        end
        vec++;
        if (!got) begin err++; $display("FAIL ack_timeout: got no clr_rx_rdy, required ack for byte %h", b); end
        cap_cyc = cyc;
        @(posedge clk); #1 rx_rdy = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        bit got = 0;
        @(posedge clk); #1;
        rx_data1 = b; rx_rdy1 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (clr1 === 1'b1) begin got = 1; break; end
        end
        vec++;
        if (!got) begin err++; $display("FAIL ack1_timeout: got no clr_rx_rdy, required ack"); end
        @(posedge clk); #1 rx_rdy1 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_rdy = 1'b0; core_done = 1'b0; core_addr = '0;
        rx_rdy1 = 1'b0; core_done1 = 1'b0; core_addr1 = '0;
        #25;
        exp_q.delete(); exp_addr = 0;
        start_cnt = 0; le_cnt = 0; w1_cnt = 0; start1_cnt = 0;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic drain();
        repeat (12) @(negedge clk);
        vec++;
        if (exp_q.size() != 0) begin err++; $display("FAIL drain: got %0d pending writes, required 0", exp_q.size()); end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_rdy = 1'b1; rx_data = 8'hFF; core_addr = 10'h3FF; core_done = 1'b1;
        rx_rdy1 = 1'b0; rx_data1 = 8'h00; core_addr1 = '0; core_done1 = 1'b0;
        repeat (2) @(negedge clk);
        vec++;
        if ({clr_rx_rdy, start, ram_we, ram_wdata, busy, load_err} !== 6'b0 || ram_addr !== '0) begin
            err++;
            $display("FAIL reset_outs: got clr=%b st=%b we=%b wd=%b busy=%b le=%b addr=%h, required all 0",
                     clr_rx_rdy, start, ram_we, ram_wdata, busy, load_err, ram_addr);
        end
        rx_rdy = 1'b0; core_addr = '0;
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if (busy !== 1'b0 || start_cnt != 0) begin
            err++; $display("FAIL idle_core_done: got busy=%b starts=%0d, required busy=0 starts=0", busy, start_cnt);
        end
        core_done = 1'b0;
    endtask

    task automatic test_frame();
        do_reset();
        for (int i = 0; i < 98; i++) send_byte(8'hA5);
        for (int k = 0; k < 30 && start_cnt == 0; k++) @(negedge clk);
        drain();
        vec++;
        if (start_cnt != 1) begin err++; $display("FAIL start_count: got %0d, required 1", start_cnt); end
        vec++;
        if (start_cyc - cap_cyc != 9) begin err++; $display("FAIL start_latency: got %0d, required 9", start_cyc - cap_cyc); end
        @(posedge clk); #1 core_addr = 10'h123;
        @(negedge clk);
        vec++;
        if (ram_addr !== 10'h123 || ram_we !== 1'b0 || busy !== 1'b1) begin
            err++; $display("FAIL run_addr: got addr=%h we=%b busy=%b, required 123 0 1", ram_addr, ram_we, busy);
        end
        @(posedge clk); #1 core_done = 1'b1;
        @(posedge clk); #1 core_done = 1'b0;
        @(negedge clk);
        vec++;
        if (busy !== 1'b0 || ram_addr !== 10'h123) begin
            err++; $display("FAIL run_done: got busy=%b addr=%h, required busy=0 addr=123", busy, ram_addr);
        end
        send_byte(8'h3C);
        drain();
    endtask

    task automatic test_hold();
        do_reset();
        send_byte(8'h81);
        rx_rdy = 1'b1; rx_data = 8'h5A;
        push_byte(8'h5A);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vec++;
            if (clr_rx_rdy !== 1'b0) begin err++; $display("FAIL hold_no_ack: got clr=%b in shift %0d, required 0", clr_rx_rdy, k); end
        end
        @(negedge clk);
        vec++;
        if (clr_rx_rdy !== 1'b1) begin err++; $display("FAIL hold_ack: got clr=%b, required 1", clr_rx_rdy); end
        @(posedge clk); #1 rx_rdy = 1'b0;
        drain();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(8'h0F);
`ifdef LOAD_TIMEOUT_EN
        for (int k = 0; k < 200 && le_cnt == 0; k++) @(negedge clk);
        vec++;
        if (le_cyc - cap_cyc != 109 || busy !== 1'b0) begin
            err++; $display("FAIL timeout: got at %0d busy=%b, required at 109 busy=0", le_cyc - cap_cyc, busy);
        end
        repeat (5) @(negedge clk);
        vec++;
        if (le_cnt != 1) begin err++; $display("FAIL timeout_pulse: got %0d, required 1", le_cnt); end
        exp_addr = 0;
`else
        repeat (300) @(negedge clk);
        vec++;
        if (le_cnt != 0 || busy !== 1'b1) begin
            err++; $display("FAIL no_timeout: got le=%0d busy=%b, required 0 1", le_cnt, busy);
        end
`endif
        send_byte(8'hC3);
        drain();
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < 50; i++) send_byte(8'h96);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1; rx_rdy = 1'b0;
        #1;
        vec++;
        if ({clr_rx_rdy, start, ram_we, ram_wdata, busy, load_err} !== 6'b0 || ram_addr !== '0) begin
            err++; $display("FAIL midreset_outs: got we=%b busy=%b addr=%h, required 0", ram_we, busy, ram_addr);
        end
        vec++;
        if (exp_q.size() != 5) begin err++; $display("FAIL midreset_writes: got %0d left, required 5", exp_q.size()); end
        exp_q.delete(); exp_addr = 0;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        vec++;
        if (busy !== 1'b0) begin err++; $display("FAIL midreset_busy: got %b, required 0", busy); end
        send_byte(8'h5A);
        drain();
    endtask

    task automatic test_small_frame();
        do_reset();
        for (int i = 0; i < 3; i++) send1(8'hFF);
        repeat (20) @(negedge clk);
        vec++;
        if (w1_cnt != NP1 || w1_last != NP1 - 1) begin
            err++; $display("FAIL small_count: got %0d writes last=%0d, required 20 last=19", w1_cnt, w1_last);
        end
        vec++;
        if (start1_cnt != 1 || busy1 !== 1'b1) begin
            err++; $display("FAIL small_start: got starts=%0d busy=%b, required 1 1", start1_cnt, busy1);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_hold();
        test_timeout();
        test_midreset();
        test_small_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/input_load_sequencer.md
INPUT_LOAD_SEQUENCER -- requirements
Module: input_load_sequencer

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 784, meaning the number of 1-bit image locations written per frame.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning the RAM address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the inter-byte timeout in clocks, used only with LOAD_TIMEOUT_EN.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: system clock, 50 MHz.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port rx_rdy, input, 1 bit: received byte pending, level.
REQ-008 SHALL have port rx_data, input, 8 bits: received byte.
REQ-009 SHALL have port clr_rx_rdy, output, 1 bit: one-cycle pulse acknowledging rx_rdy.
REQ-010 SHALL have port core_addr, input, ADDR_WIDTH bits: snn_core read address.
REQ-011 SHALL have port core_done, input, 1 bit: snn_core finished the frame.
REQ-012 SHALL have port start, output, 1 bit: one-cycle pulse launching snn_core.
REQ-013 SHALL have port ram_we, output, 1 bit: input RAM write enable.
REQ-014 SHALL have port ram_addr, output, ADDR_WIDTH bits: input RAM address.
REQ-015 SHALL have port ram_wdata, output, 1 bit: input RAM write data.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port load_err, output, 1 bit: one-cycle pulse on load timeout abort.

Function
REQ-018 SHALL have states IDLE, WAIT_BYTE, SHIFT, START, RUN.
REQ-019 In IDLE or WAIT_BYTE with rx_rdy=1, SHALL capture rx_data, pulse clr_rx_rdy for that cycle, and go to SHIFT next cycle.
REQ-020 In SHIFT, SHALL write one bit per cycle, MSB first: ram_we=1, ram_wdata=shift[7], ram_addr=wr_addr; then shift left and increment wr_addr.
REQ-021 SHALL leave SHIFT after the 8th bit, or immediately after writing address NUM_PIXELS-1; any remaining byte bits SHALL be discarded.
REQ-022 After a frame's final write (address NUM_PIXELS-1), SHALL go to START; otherwise SHALL go to WAIT_BYTE.
REQ-023 START SHALL last exactly one cycle with start=1, then go to RUN.
REQ-024 In RUN, SHALL hold ram_we=0 and wait for core_done=1, then clear wr_addr to 0 and return to IDLE.
REQ-025 ram_addr SHALL equal wr_addr in SHIFT and core_addr in all other states.
REQ-026 ram_we SHALL be 1 only in SHIFT.
REQ-027 rx_rdy in SHIFT, START or RUN SHALL NOT be acknowledged; it SHALL stay pending until the next IDLE or WAIT_BYTE cycle.
REQ-028 core_done outside RUN SHALL be ignored.
REQ-029 A 784-pixel frame SHALL take exactly 98 bytes; latency from the last byte's capture to start SHALL be 9 cycles (8 SHIFT + 1).

Reset
REQ-030 rst SHALL asynchronously force IDLE, wr_addr=0, shift=0, bit counter=0, and all outputs to 0, including mid-SHIFT or mid-RUN.

Configuration
REQ-031 Macro LOAD_TIMEOUT_EN: when defined, SHALL count cycles in WAIT_BYTE, restarting at 0 on entry.
REQ-032 When the count reaches TIMEOUT_CYCLES, SHALL pulse load_err for one cycle, clear wr_addr, and return to IDLE.
REQ-033 When LOAD_TIMEOUT_EN is undefined, SHALL tie load_err to 0 and include no counter logic.

Structure
REQ-034 Package snn_pkg SHALL hold the state enum seq_state_t, default NUM_PIXELS=784, and BYTE_BITS=8.
REQ-035 SHALL use sub-module byte_serializer (load, shift enable, 8-bit register, 3-bit counter, last_bit flag); all else stays inline.

Verification
REQ-036 Reset, then stream 98 bytes 0xA5: RAM addr 0..783 = 1,0,1,0,0,1,0,1 repeating; exactly one start pulse, 9 cycles after capture of byte 98.
REQ-037 rx_rdy held high during SHIFT of byte 1: clr_rx_rdy stays 0 until WAIT_BYTE, then pulses once; byte 2 is written at addr 8..15.
REQ-038 In RUN with core_addr=0x123: ram_addr=0x123 and ram_we=0; core_done -> IDLE, and the next byte is written starting at addr 0.
REQ-039 NUM_PIXELS=20 with 3 bytes 0xFF: exactly 20 writes, last at addr 19; remaining 4 bits discarded; then start.
REQ-040 LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=100: 5 bytes then silence -> load_err pulse 100 cycles into WAIT_BYTE, IDLE; the next frame starts at addr 0.
REQ-041 rst asserted on the 4th SHIFT cycle of byte 50: outputs 0 at once; after release, busy=0 and wr_addr=0.
